// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: writeback-select
// encodings, the shadow scoreboard entry, and the register-match helper.
package hazard_ctrl_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DRAM = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_EXT  = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] wR;
    logic [1:0] wsel;
  } sb_entry_t;

  // x0 is hard-wired zero, so it can never be a real producer.
  function automatic logic sbMatch(input sb_entry_t s, input logic [4:0] r);
    return s.v && (s.wR == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle. The master is the pipeline side
// that supplies decode/writeback information; the slave is hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       ID_rR1;
  logic [4:0]       ID_rR2;
  logic             ID_re1;
  logic             ID_re2;
  logic             ID_rf_we;
  logic [4:0]       ID_wR;
  logic [1:0]       ID_rf_wsel;
  logic [31:0]      ID_rD1;
  logic [31:0]      ID_rD2;
  logic [31:0]      EX_wd;
  logic [31:0]      MEM_wd;
  logic [31:0]      WB_wd;
  logic             EX_taken;
  logic             stall;
  logic             data_hazard;
  logic             control_hazard;
  logic [31:0]      fwd_rD1;
  logic [31:0]      fwd_rD2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_rR1, ID_rR2, ID_re1, ID_re2, ID_rf_we, ID_wR, ID_rf_wsel,
           ID_rD1, ID_rD2, EX_wd, MEM_wd, WB_wd, EX_taken,
    input  stall, data_hazard, control_hazard, fwd_rD1, fwd_rD2,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rR1, ID_rR2, ID_re1, ID_re2, ID_rf_we, ID_wR, ID_rf_wsel,
           ID_rD1, ID_rD2, EX_wd, MEM_wd, WB_wd, EX_taken,
    output stall, data_hazard, control_hazard, fwd_rD1, fwd_rD2,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_mux.sv
// Per-operand forwarding select: the youngest in-flight producer wins,
// falling back to the register-file read data.
module hazard_fwd_mux (
  input  logic        hitEx_i,
  input  logic        hitMem_i,
  input  logic        hitWb_i,
  input  logic [31:0] exWd_i,
  input  logic [31:0] memWd_i,
  input  logic [31:0] wbWd_i,
  input  logic [31:0] rfD_i,
  output logic [31:0] fwd_o
);

  // Priority EX > MEM > WB > register file.
  always_comb begin
    fwd_o = rfD_i;
    if (hitEx_i)       fwd_o = exWd_i;
    else if (hitMem_i) fwd_o = memWd_i;
    else if (hitWb_i)  fwd_o = wbWd_i;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside the ID stage: shadow scoreboard of in-flight
// writebacks, load-use / no-forwarding stall detection, branch flush,
// operand forwarding and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input logic        clk,
  input logic        rst,
  hazard_ctrl_if.slave hz
);

  sb_entry_t        sbEx_q, sbMem_q, sbWb_q, sbEx_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic use1, use2;
  logic ex1, mem1, wb1, ex2, mem2, wb2;
  logic exLoad;
  logic dataRaw, dataHazard, controlHazard;
  logic hitEx1, hitMem1, hitWb1, hitEx2, hitMem2, hitWb2;

  assign use1   = hz.ID_re1 & (hz.ID_rR1 != 5'd0);
  assign use2   = hz.ID_re2 & (hz.ID_rR2 != 5'd0);
  assign ex1    = use1 & sbMatch(sbEx_q,  hz.ID_rR1);
  assign mem1   = use1 & sbMatch(sbMem_q, hz.ID_rR1);
  assign wb1    = use1 & sbMatch(sbWb_q,  hz.ID_rR1);
  assign ex2    = use2 & sbMatch(sbEx_q,  hz.ID_rR2);
  assign mem2   = use2 & sbMatch(sbMem_q, hz.ID_rR2);
  assign wb2    = use2 & sbMatch(sbWb_q,  hz.ID_rR2);
  assign exLoad = (sbEx_q.wsel == WB_DRAM);

  // Hazard detection and forwarding hits depend on whether bypass paths exist.
  always_comb begin
    dataRaw = 1'b0;
    hitEx1  = 1'b0;
    hitMem1 = 1'b0;
    hitWb1  = 1'b0;
    hitEx2  = 1'b0;
    hitMem2 = 1'b0;
    hitWb2  = 1'b0;
    if (FWD_EN != 0) begin
      dataRaw = (ex1 | ex2) & exLoad;
      hitEx1  = ex1 & ~exLoad;
      hitMem1 = mem1;
      hitWb1  = wb1;
      hitEx2  = ex2 & ~exLoad;
      hitMem2 = mem2;
      hitWb2  = wb2;
    end else begin
      dataRaw = ex1 | mem1 | wb1 | ex2 | mem2 | wb2;
    end
  end

  // A taken branch squashes the ID instruction, so no bubble/stall is needed.
  assign controlHazard     = hz.EX_taken;
  assign dataHazard        = dataRaw & ~controlHazard;
  assign hz.control_hazard = controlHazard;
  assign hz.data_hazard    = dataHazard;
  assign hz.stall          = dataHazard;

  // Entry entering EX is the ID instruction unless it is bubbled or flushed.
  always_comb begin
    sbEx_d = '0;
    if (!(dataHazard | controlHazard)) begin
      sbEx_d.v    = hz.ID_rf_we & (hz.ID_wR != 5'd0);
      sbEx_d.wR   = hz.ID_wR;
      sbEx_d.wsel = hz.ID_rf_wsel;
    end
  end

  // Saturating event counters: hold at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (dataHazard && (stallCnt_q != '1))
      stallCnt_d = stallCnt_q + CNT_W'(1);
    if (controlHazard && (flushCnt_q != '1))
      flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  // Scoreboard shift mirroring the EX/MEM/WB pipeline registers, plus counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbEx_q     <= '0;
      sbMem_q    <= '0;
      sbWb_q     <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      sbEx_q     <= sbEx_d;
      sbMem_q    <= sbEx_q;
      sbWb_q     <= sbMem_q;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign hz.stall_cnt = stallCnt_q;
  assign hz.flush_cnt = flushCnt_q;

  hazard_fwd_mux u_fwd1 (
    .hitEx_i  (hitEx1),
    .hitMem_i (hitMem1),
    .hitWb_i  (hitWb1),
    .exWd_i   (hz.EX_wd),
    .memWd_i  (hz.MEM_wd),
    .wbWd_i   (hz.WB_wd),
    .rfD_i    (hz.ID_rD1),
    .fwd_o    (hz.fwd_rD1)
  );

  hazard_fwd_mux u_fwd2 (
    .hitEx_i  (hitEx2),
    .hitMem_i (hitMem2),
    .hitWb_i  (hitWb2),
    .exWd_i   (hz.EX_wd),
    .memWd_i  (hz.MEM_wd),
    .wbWd_i   (hz.WB_wd),
    .rfD_i    (hz.ID_rD2),
    .fwd_o    (hz.fwd_rD2)
  );

endmodule
